serial_frame_rx: RTL and testbench
==================================

// Module: serial_frame_rx
// PURPOSE
//   Consumes the 1-bit serial stream that also feeds the 4-bit shift_reg stage.
//   Hunts for a fixed sync pattern, then assembles a DATA_W-bit payload (MSB first).
//   Checks one trailing even-parity bit, presents the word with a 1-cycle valid pulse
//   and counts good frames. Sits directly downstream of the serial input pin/shifter.
// PARAMETERS
//   SYNC_W  4        width of sync pattern (>=2)
//   SYNC    4'b1011  sync pattern; last bit received = LSB
//   DATA_W  8        payload bits per frame (>=2)
//   CNT_W   8        width of good-frame counter (saturating)
// PORTS
//   clk        in   1       single clock, all logic on rising edge
//   rst        in   1       asynchronous, active-high reset
//   in         in   1       serial data bit
//   in_en      in   1       in is sampled only when in_en=1
//   clr        in   1       synchronous clear: abort frame, zero counter
//   out_data   out  DATA_W  last completed payload, held until next frame completes
//   out_valid  out  1       1-cycle pulse: out_data/out_perr updated
//   out_perr   out  1       1 = parity error on frame flagged by out_valid
//   busy       out  1       1 while in COLLECT or PARITY
//   frame_cnt  out  CNT_W   good (parity-ok) frames since reset/clr, saturates at all-ones
// BEHAVIOUR
//   Reset (rst=1, async): state=HUNT; window, fill count, bit count = 0.
//     Also out_data=0, out_valid=0, out_perr=0, busy=0, frame_cnt=0.
//   States: HUNT -> COLLECT -> PARITY -> HUNT. Any accepted bit = clk edge with in_en=1.
//   HUNT: window <= {window[SYNC_W-2:0], in}; fill count increments to SYNC_W and saturates.
//     Match = fill reached SYNC_W AND post-shift window == SYNC.
//     On match -> COLLECT, bit_cnt=0. Overlapping sync allowed: stream 1,0,1,0,1,1
//       matches on the 6th bit.
//   COLLECT: data_sr <= {data_sr[DATA_W-2:0], in}; bit_cnt++.
//     The accepted bit with bit_cnt==DATA_W-1 -> PARITY.
//     Sync patterns inside the payload are ignored.
//   PARITY: on the accepted bit p, the next edge sets out_data=data_sr,
//     out_perr = ^data_sr ^ p, and pulses out_valid=1 for one cycle.
//     frame_cnt += 1 if out_perr=0 and not saturated.
//     State -> HUNT; window and fill count cleared (no reuse of payload bits).
//   Latency: out_valid is high the cycle after the edge that sampled the parity bit.
//   in_en=0: state, window and counters hold; out_valid still drops after its single cycle.
//   busy = (state != HUNT), registered alongside state.
//   clr=1: same effect as reset but synchronous. out_data is kept. clr wins over in_en.
//   rst mid-frame: partial payload discarded, no out_valid, restart in HUNT.
//   All counters are unsigned. bit_cnt width = $clog2(DATA_W). Fill count width = $clog2(SYNC_W+1).
// STRUCTURE
//   serial_rx_defs.vh: state localparams ST_HUNT=2'd0, ST_COLLECT=2'd1, ST_PARITY=2'd2.
//     The same include holds default SYNC/SYNC_W for the upstream serializer bench.
//   Sub-module sync_window: shift window + fill counter + compare.
//     Ports: clk, rst, clr_i, en_i, bit_i, match_o.
//     Parent FSM drives clr_i on reset-like events and on leaving PARITY.
//   Top: FSM, payload shifter, parity, output registers, saturating counter.
// TESTING (defaults SYNC=1011, DATA_W=8, T_CLK=10)
//   1 Assert rst for 10ns, hold in_en=0 -> all outputs 0, busy=0; check async clear mid-cycle.
//   2 Send 1011 + 10100101 + parity 0, in_en=1 every cycle -> one out_valid pulse;
//     out_data=8'hA5, out_perr=0, frame_cnt=1, busy low the cycle after parity.
//   3 Send 1011 + 8'hA5 + parity 1 -> out_valid with out_perr=1; frame_cnt stays at 1.
//   4 Send 10 + 1011 + 8'b10110000 + parity 1 -> sync on 6th bit; no re-sync inside payload;
//     out_data=8'hB0, out_perr=0.
//   5 Repeat scenario 2 with in_en=0 on alternate cycles -> identical result; valid is 1 cycle wide.
//   6 Assert rst (and in a second run clr) after 4 payload bits -> no out_valid, busy=0;
//     a following full 8'h3C frame (parity 0) -> out_data=8'h3C, out_valid=1.
//   7 Set CNT_W=2 and send 5 good frames -> frame_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and defaults for the serial frame receiver and its upstream serializer bench.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } rx_state_t;

  localparam int                    DEF_SYNC_W = 4;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC   = 4'b1011;

endpackage

// File: rtl/serial_frame_rx_sync_window.sv
// Sliding sync-pattern window with a saturating fill count; match is combinational on the accepted bit.
// Latency: match_o reflects the post-shift window in the same cycle the bit is offered.
// Backpressure: none; en_i gates shifting, clr_i empties the window.
module sync_window #(
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic match_o
);

  localparam int             FW   = $clog2(SYNC_W + 1);
  localparam logic [FW-1:0]  FULL = FW'(SYNC_W);

  logic [SYNC_W-1:0] window_q;
  logic [SYNC_W-1:0] window_nxt;
  logic [FW-1:0]     fill_q;
  logic [FW-1:0]     fill_nxt;

  assign window_nxt = {window_q[SYNC_W-2:0], bit_i};
  assign fill_nxt   = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
  // A partially filled window must never match, even if its stale zeros happen to line up.
  assign match_o    = en_i && !clr_i && (fill_nxt == FULL) && (window_nxt == SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (clr_i) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (en_i) begin
      window_q <= window_nxt;
      fill_q   <= fill_nxt;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, MSB-first payload, even-parity check, saturating good-frame count.
// Latency: out_valid pulses the cycle after the edge that samples the parity bit.
// Backpressure: none; in_en=0 freezes the frame state, clr aborts and zeroes the counter.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int                SYNC_W = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC   = SYNC_W'(DEF_SYNC),
  parameter int                DATA_W = 8,
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              in_en,
  input  logic              clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_perr,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] data_sr;
  logic              sync_match;
  logic              sync_en;
  logic              sync_clr;
  logic              par_done;
  logic              perr_d;

  assign sync_en  = in_en && (state_q == ST_HUNT);
  assign par_done = in_en && !clr && (state_q == ST_PARITY);
  // Leaving PARITY empties the window so payload bits are never reused as sync.
  assign sync_clr = clr || par_done;
  assign perr_d   = (^data_sr) ^ in;

  sync_window #(
    .SYNC_W (SYNC_W),
    .SYNC   (SYNC)
  ) u_sync_window (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sync_clr),
    .en_i    (sync_en),
    .bit_i   (in),
    .match_o (sync_match)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:    if (in_en && sync_match) state_d = ST_COLLECT;
      ST_COLLECT: if (in_en && bit_cnt == LAST_BIT) state_d = ST_PARITY;
      ST_PARITY:  if (in_en) state_d = ST_HUNT;
      default:    state_d = ST_HUNT;
    endcase
    if (clr) state_d = ST_HUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_HUNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr   <= '0;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_perr  <= 1'b0;
      frame_cnt <= '0;
    end else if (clr) begin
      // out_data deliberately survives a clear.
      data_sr   <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_perr  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_en) begin
        case (state_q)
          ST_HUNT: bit_cnt <= '0;
          ST_COLLECT: begin
            data_sr <= {data_sr[DATA_W-2:0], in};
            bit_cnt <= bit_cnt + BW'(1);
          end
          ST_PARITY: begin
            out_data  <= data_sr;
            out_perr  <= perr_d;
            out_valid <= 1'b1;
            if (!perr_d && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
          end
          default: bit_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default instance plus a CNT_W=2 instance sharing the stimulus.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic       in_en;
  logic       clr;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_perr;
  logic       busy;
  logic [7:0] frame_cnt;

  logic [7:0] out_data2;
  logic       out_valid2;
  logic       out_perr2;
  logic       busy2;
  logic [1:0] frame_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int vld_cnt  = 0;
  int exp_vld  = 0;

  always #5 clk = ~clk;

  serial_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_bit),
    .in_en     (in_en),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_perr  (out_perr),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  serial_frame_rx #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in        (in_bit),
    .in_en     (in_en),
    .clr       (clr),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_perr  (out_perr2),
    .busy      (busy2),
    .frame_cnt (frame_cnt2)
  );

  always @(negedge clk) if (out_valid) vld_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the posedge has sampled the bit.
  task automatic drive(input logic b, input logic en);
    in_bit = b;
    in_en  = en;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap) drive(1'b0, 1'b0);
      drive(v[i], 1'b1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input bit gap);
    send_bits(32'b1011, 4, gap);
    send_bits({24'd0, d}, 8, gap);
    send_bits({31'd0, p}, 1, gap);
  endtask

  task automatic idle_check_drop(input string tag);
    drive(1'b0, 1'b0);
    check(tag, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_bit = 1'b0; in_en = 1'b0; clr = 1'b0;
    // 1: reset is applied before any clock edge
    #2;
    check("rst_data",  out_data,  8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_perr",  out_perr,  1'b0);
    check("rst_busy",  busy,      1'b0);
    check("rst_cnt",   frame_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0);

    // 2: good frame A5
    send_bits(32'b1011, 4, 1'b0);
    check("t2_busy_collect", busy, 1'b1);
    send_bits(32'hA5, 8, 1'b0);
    check("t2_busy_parity", busy, 1'b1);
    send_bits(32'd0, 1, 1'b0);
    exp_vld++;
    check("t2_valid", out_valid, 1'b1);
    check("t2_data",  out_data,  8'hA5);
    check("t2_perr",  out_perr,  1'b0);
    check("t2_cnt",   frame_cnt, 8'd1);
    check("t2_busy",  busy,      1'b0);
    idle_check_drop("t2_valid_drop");

    // 3: bad parity
    send_frame(8'hA5, 1'b1, 1'b0);
    exp_vld++;
    check("t3_valid", out_valid, 1'b1);
    check("t3_perr",  out_perr,  1'b1);
    check("t3_cnt",   frame_cnt, 8'd1);
    idle_check_drop("t3_valid_drop");

    // 4: overlapping sync, payload containing the sync pattern
    send_bits(32'b10101, 5, 1'b0);
    check("t4_no_early_sync", busy, 1'b0);
    send_bits(32'b1, 1, 1'b0);
    check("t4_sync_6th", busy, 1'b1);
    send_bits(32'hB0, 8, 1'b0);
    send_bits(32'd1, 1, 1'b0);
    exp_vld++;
    check("t4_valid", out_valid, 1'b1);
    check("t4_data",  out_data,  8'hB0);
    check("t4_perr",  out_perr,  1'b0);
    check("t4_cnt",   frame_cnt, 8'd2);
    idle_check_drop("t4_valid_drop");

    // 5: in_en low on alternate cycles
    send_frame(8'hA5, 1'b0, 1'b1);
    exp_vld++;
    check("t5_valid", out_valid, 1'b1);
    check("t5_data",  out_data,  8'hA5);
    check("t5_perr",  out_perr,  1'b0);
    check("t5_cnt",   frame_cnt, 8'd3);
    idle_check_drop("t5_valid_drop");
    check("t5_pulses", vld_cnt, exp_vld);

    // 6a: async reset after 4 payload bits
    send_bits(32'b1011, 4, 1'b0);
    send_bits(32'b0011, 4, 1'b0);
    check("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy_async", busy,      1'b0);
    check("t6_rst_cnt_async",  frame_cnt, 8'd0);
    check("t6_rst_data_async", out_data,  8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0);
    check("t6_rst_no_valid", vld_cnt, exp_vld);
    send_frame(8'h3C, 1'b0, 1'b0);
    exp_vld++;
    check("t6_valid", out_valid, 1'b1);
    check("t6_data",  out_data,  8'h3C);
    check("t6_cnt",   frame_cnt, 8'd1);
    idle_check_drop("t6_valid_drop");

    // 6b: synchronous clear after 4 payload bits, with in_en high
    send_bits(32'b1011, 4, 1'b0);
    send_bits(32'b0101, 4, 1'b0);
    clr = 1'b1;
    drive(1'b1, 1'b1);
    clr = 1'b0;
    check("t6_clr_busy", busy,      1'b0);
    check("t6_clr_cnt",  frame_cnt, 8'd0);
    check("t6_clr_data", out_data,  8'h3C);
    drive(1'b0, 1'b0);
    check("t6_clr_no_valid", vld_cnt, exp_vld);
    send_frame(8'h3C, 1'b0, 1'b0);
    exp_vld++;
    check("t6c_valid", out_valid, 1'b1);
    check("t6c_data",  out_data,  8'h3C);
    check("t6c_cnt",   frame_cnt, 8'd1);
    idle_check_drop("t6c_valid_drop");

    // 7: 2-bit saturating counter
    clr = 1'b1;
    drive(1'b0, 1'b0);
    clr = 1'b0;
    check("t7_clr_cnt", frame_cnt2, 2'd0);
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA5, 1'b0, 1'b0);
      exp_vld++;
      check($sformatf("t7_cnt_%0d", k), frame_cnt2, (k < 3) ? k + 1 : 3);
      if (k == 4) begin
        check("t7_valid2", out_valid2, 1'b1);
        check("t7_data2",  out_data2,  8'hA5);
        check("t7_perr2",  out_perr2,  1'b0);
        check("t7_busy2",  busy2,      1'b0);
        check("t7_cnt_wide", frame_cnt, 8'd5);
      end
      drive(1'b0, 1'b0);
    end
    check("t7_pulses", vld_cnt, exp_vld);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
